// File: rtl/prio_scan_enc.sv
// Purpose: sequential priority scanner. It accepts a WIDTH-bit request vector and emits each set index in priority order.
// Latency: the first beat appears the cycle after accept. After that it emits one index per cycle while out_ready is high.
// Backpressure: out_valid/out_ready stalls hold every output stable. in_ready is high only in IDLE, so there is no queueing.
//
// Ports:
//   clk, rst               clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready      request vector handshake; in_vec is sampled only on accept
//   in_vec [WIDTH]         request vector, bit i = request i
//   out_valid/out_ready    index beat handshake
//   out_idx [IDX_W]        highest-priority remaining index (0 for an all-zero vector)
//   out_last               final beat of the current vector
//   out_none               accepted vector was all-zero (single beat)
//   out_seq [IDX_W+1]      0-based beat number within the vector
module prio_scan_enc #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_seq
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             none_q,  none_d;
    logic [IDX_W:0]   seq_q,   seq_d;

    logic [IDX_W-1:0] enc_idx;
    logic [WIDTH-1:0] pend_rest;
    logic             scan;
    logic             last;

    // Priority encode. The scan direction is chosen so that the winning bit
    // is the last one visited. The result is 0 when pend is empty.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (pend_q[i]) enc_idx = IDX_W'(i);
            end else begin
                if (pend_q[WIDTH-1-i]) enc_idx = IDX_W'(WIDTH-1-i);
            end
        end
    end

    // The pending set that remains after the current beat is consumed.
    always_comb begin
        pend_rest          = pend_q;
        pend_rest[enc_idx] = 1'b0;
    end

    assign scan      = (state_q == SCAN);
    assign last      = none_q || (pend_rest == '0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = scan;
    assign out_none  = scan && none_q;
    // Gate with scan so that outputs stay quiet in IDLE, where pend is empty.
    assign out_last  = scan && last;
    assign out_idx   = (scan && !none_q) ? enc_idx : '0;
    assign out_seq   = scan ? seq_q : '0;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    none_d  = (in_vec == '0);
                    seq_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (last) begin
                        state_d = IDLE;
                        pend_d  = '0;
                        none_d  = 1'b0;
                    end else begin
                        pend_d = pend_rest;
                        seq_d  = seq_q + (IDX_W+1)'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
            seq_q   <= seq_d;
        end
    end

endmodule

// File: tb/tb_prio_scan_enc.sv
module tb_prio_scan_enc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Two 16-bit instances (MSB-first and LSB-first) share the same stimulus.
    logic        in_valid = 1'b0;
    logic [15:0] in_vec   = '0;
    logic        out_ready = 1'b0;
    logic        m_in_ready, m_out_valid, m_out_last, m_out_none;
    logic [3:0]  m_out_idx;
    logic [4:0]  m_out_seq;
    logic        l_in_ready, l_out_valid, l_out_last, l_out_none;
    logic [3:0]  l_out_idx;
    logic [4:0]  l_out_seq;

    prio_scan_enc #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_last(m_out_last), .out_none(m_out_none), .out_seq(m_out_seq));

    prio_scan_enc #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_vec(in_vec),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_none(l_out_none), .out_seq(l_out_seq));

    // 32-bit boundary instance.
    logic        v32 = 1'b0;
    logic [31:0] vec32 = '0;
    logic        rdy32 = 1'b0;
    logic        w_in_ready, w_out_valid, w_out_last, w_out_none;
    logic [4:0]  w_out_idx;
    logic [5:0]  w_out_seq;

    prio_scan_enc #(.WIDTH(32), .MSB_FIRST(1'b1)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(w_in_ready), .in_vec(vec32),
        .out_valid(w_out_valid), .out_ready(rdy32), .out_idx(w_out_idx),
        .out_last(w_out_last), .out_none(w_out_none), .out_seq(w_out_seq));

    // 2-bit boundary instance.
    logic        v2 = 1'b0;
    logic [1:0]  vec2 = '0;
    logic        rdy2 = 1'b0;
    logic        n_in_ready, n_out_valid, n_out_last, n_out_none;
    logic [0:0]  n_out_idx;
    logic [1:0]  n_out_seq;

    prio_scan_enc #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(n_in_ready), .in_vec(vec2),
        .out_valid(n_out_valid), .out_ready(rdy2), .out_idx(n_out_idx),
        .out_last(n_out_last), .out_none(n_out_none), .out_seq(n_out_seq));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The expected index lists are packed as nibbles, first beat in [15:12].
    typedef struct packed {
        logic [15:0] vec;
        logic [2:0]  n;
        logic        none;
        logic [15:0] msb_idx;
        logic [15:0] lsb_idx;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one vector through both 16-bit instances with out_ready held high.
    task automatic run_vec(input vec_t r);
        logic [15:0] tm, tl;
        chk("accept_rdy_m", {31'd0, m_in_ready}, 32'd1);
        in_valid = 1'b1;
        in_vec   = r.vec;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_vec   = 16'hDEAD;   // must not affect the scan: sampled only on accept
        for (int b = 0; b < int'(r.n); b++) begin
            tm = r.msb_idx << (4 * b);
            tl = r.lsb_idx << (4 * b);
            chk("m_valid", {31'd0, m_out_valid}, 32'd1);
            chk("m_in_ready_busy", {31'd0, m_in_ready}, 32'd0);
            chk("m_idx",   {28'd0, m_out_idx}, {28'd0, tm[15:12]});
            chk("l_idx",   {28'd0, l_out_idx}, {28'd0, tl[15:12]});
            chk("m_seq",   {27'd0, m_out_seq}, 32'(b));
            chk("l_seq",   {27'd0, l_out_seq}, 32'(b));
            chk("m_last",  {31'd0, m_out_last}, {31'd0, (b == int'(r.n) - 1)});
            chk("l_last",  {31'd0, l_out_last}, {31'd0, (b == int'(r.n) - 1)});
            chk("m_none",  {31'd0, m_out_none}, {31'd0, r.none});
            chk("l_none",  {31'd0, l_out_none}, {31'd0, r.none});
            tick();
        end
        chk("m_end_valid", {31'd0, m_out_valid}, 32'd0);
        chk("m_end_ready", {31'd0, m_in_ready}, 32'd1);
        chk("l_end_ready", {31'd0, l_in_ready}, 32'd1);
        in_vec = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        tbl[0] = '{vec:16'h8421, n:3'd4, none:1'b0, msb_idx:16'hFA50, lsb_idx:16'h05AF};
        tbl[1] = '{vec:16'h0000, n:3'd1, none:1'b1, msb_idx:16'h0000, lsb_idx:16'h0000};
        tbl[2] = '{vec:16'h0001, n:3'd1, none:1'b0, msb_idx:16'h0000, lsb_idx:16'h0000};
        tbl[3] = '{vec:16'h8000, n:3'd1, none:1'b0, msb_idx:16'hF000, lsb_idx:16'hF000};
        tbl[4] = '{vec:16'h0300, n:3'd2, none:1'b0, msb_idx:16'h9800, lsb_idx:16'h8900};
        tbl[5] = '{vec:16'h1010, n:3'd2, none:1'b0, msb_idx:16'hC400, lsb_idx:16'h4C00};

        // Values while reset is held.
        #12;
        chk("rst_in_ready",  {31'd0, m_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("rst_out_idx",   {28'd0, m_out_idx}, 32'd0);
        chk("rst_out_last",  {31'd0, m_out_last}, 32'd0);
        chk("rst_out_none",  {31'd0, m_out_none}, 32'd0);
        chk("rst_out_seq",   {27'd0, m_out_seq}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // Backpressure: idx 9 is held for three stalled cycles, and a competing vector is ignored.
        in_valid = 1'b1;
        in_vec   = 16'h0300;
        out_ready = 1'b0;
        tick();
        in_vec = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", {31'd0, m_out_valid}, 32'd1);
            chk("bp_idx",   {28'd0, m_out_idx}, 32'd9);
            chk("bp_seq",   {27'd0, m_out_seq}, 32'd0);
            chk("bp_last",  {31'd0, m_out_last}, 32'd0);
            chk("bp_in_ready", {31'd0, m_in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_beat0_idx", {28'd0, m_out_idx}, 32'd9);
        tick();
        chk("bp_beat1_idx",  {28'd0, m_out_idx}, 32'd8);
        chk("bp_beat1_seq",  {27'd0, m_out_seq}, 32'd1);
        chk("bp_beat1_last", {31'd0, m_out_last}, 32'd1);
        tick();
        chk("bp_done_valid", {31'd0, m_out_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, m_in_ready}, 32'd1);

        // Reset mid-scan with pend 00F0: the scan must drop without waiting for a clock edge.
        in_valid = 1'b1;
        in_vec   = 16'h00F0;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid_idx_before", {28'd0, m_out_idx}, 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid_m", {31'd0, m_out_valid}, 32'd0);
        chk("mid_rst_ready_m", {31'd0, m_in_ready}, 32'd1);
        chk("mid_rst_valid_l", {31'd0, l_out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, m_out_valid}, 32'd0);
        r = '{vec:16'h0001, n:3'd1, none:1'b0, msb_idx:16'h0000, lsb_idx:16'h0000};
        run_vec(r);

        // WIDTH=32, all-ones vector: expect 32 beats, idx 31..0.
        v32 = 1'b1;
        vec32 = 32'hFFFF_FFFF;
        rdy32 = 1'b1;
        tick();
        v32 = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk("w32_valid", {31'd0, w_out_valid}, 32'd1);
            chk("w32_idx",   {27'd0, w_out_idx}, 32'(31 - b));
            chk("w32_seq",   {26'd0, w_out_seq}, 32'(b));
            chk("w32_last",  {31'd0, w_out_last}, {31'd0, (b == 31)});
            tick();
        end
        chk("w32_end_valid", {31'd0, w_out_valid}, 32'd0);
        chk("w32_end_ready", {31'd0, w_in_ready}, 32'd1);
        chk("w32_none",      {31'd0, w_out_none}, 32'd0);

        // WIDTH=2 with vector 2'b10: expect a single beat, idx 1.
        v2 = 1'b1;
        vec2 = 2'b10;
        rdy2 = 1'b1;
        tick();
        v2 = 1'b0;
        chk("w2_valid", {31'd0, n_out_valid}, 32'd1);
        chk("w2_idx",   {31'd0, n_out_idx}, 32'd1);
        chk("w2_last",  {31'd0, n_out_last}, 32'd1);
        chk("w2_seq",   {30'd0, n_out_seq}, 32'd0);
        chk("w2_none",  {31'd0, n_out_none}, 32'd0);
        tick();
        chk("w2_end_valid", {31'd0, n_out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_scan_enc.md
Name: prio_scan_enc

Overview:
Parametrised, sequential successor to the 16-input structural priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. It then emits the index of every set bit, one per output beat, in priority order, until the vector is exhausted. It serves interrupt/request servicing paths that need all active requests, not just the highest one.

Parameters:
WIDTH, 16, request vector width; legal range 2..256.
MSB_FIRST, 1, 1 = highest index has priority (matches existing encoders); 0 = lowest index first.
IDX_W, $clog2(WIDTH), derived; width of the index output; not to be overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request vector offered.
in_ready  output  1  block can accept a vector.
in_vec  input  WIDTH  request vector; bit i = request i.
out_valid  output  1  out_idx/out_last/out_none/out_seq are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDX_W  index of the current highest-priority remaining bit.
out_last  output  1  current beat is the final beat for this vector.
out_none  output  1  accepted vector was all-zero (single beat, idx 0).
out_seq  output  IDX_W+1  beat number within the current vector, 0-based.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Registers: state {IDLE, SCAN}, pend[WIDTH], none_r, seq[IDX_W+1].
- Reset values: state=IDLE, pend=0, none_r=0, seq=0.
- Outputs during reset: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0, out_seq=0.
- in_ready = (state==IDLE). It is a pure function of state, with no combinational path from out_ready.
- Accept = in_valid && in_ready. On accept:
  - pend <= in_vec; none_r <= (in_vec==0); seq <= 0; state <= SCAN.
  - in_vec is sampled only on that edge.
- out_valid = (state==SCAN).
- Latency: first beat is presented the cycle after accept.
- out_idx is a combinational priority encode of pend:
  - MSB_FIRST=1: highest set bit.
  - MSB_FIRST=0: lowest set bit.
  - Forced to 0 when out_none.
- out_none = none_r while in SCAN, else 0.
- out_last = out_none OR (pend with bit out_idx cleared == 0).
- out_seq = seq while in SCAN, else 0.
- Beat transfer = out_valid && out_ready:
  - If out_last: state <= IDLE, pend <= 0, none_r <= 0.
  - Else: pend[out_idx] <= 0; seq <= seq+1.
- Stall: while out_valid && !out_ready, all outputs hold stable. pend and seq do not change.
- Throughput: one index per cycle while out_ready=1.
- Per-vector cost: a vector with K set bits (K>=1) occupies K beats plus one idle cycle, since in_ready returns the cycle after the last transfer. A zero vector occupies exactly one beat.
- in_valid while in SCAN is ignored. The source must hold the vector until in_ready. No queueing.
- Reset mid-scan: pend is cleared immediately (asynchronously) and out_valid drops. The partially scanned vector is discarded with no further beats.
- seq never exceeds WIDTH-1. A full all-ones vector yields seq 0..WIDTH-1 with out_last on seq=WIDTH-1.
- No X propagation: out_idx is defined (0) when pend==0.

Test Plan:
- Reset: assert rst mid-SCAN with pend=16'h00F0 -> out_valid=0, in_ready=1 asynchronously. After release, a new vector 16'h0001 yields a single beat idx=0, last=1.
- Basic scan (WIDTH=16, MSB_FIRST=1), in_vec=16'h8421, out_ready=1 -> beats idx 15,10,5,0, seq 0..3, last only on idx 0. in_ready high on the 5th cycle after accept.
- LSB order (MSB_FIRST=0), in_vec=16'h8421 -> idx 0,5,10,15, last on idx 15.
- Zero vector 16'h0000 -> exactly one beat, out_none=1, idx=0, last=1, seq=0. Then IDLE.
- Backpressure: in_vec=16'h0300, out_ready low for 3 cycles -> idx=9 held stable for 3 cycles. Then idx 9, then 8 (last). in_valid with 16'hFFFF during SCAN is not accepted.
- Full/boundary (WIDTH=32): in_vec=all-ones, out_ready=1 -> 32 beats idx 31..0, seq 0..31, last on idx 0. WIDTH=2 with in_vec=2'b10 -> single beat idx=1, last=1.
